// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the control unit (master)
// and the iterative multiply/divide unit (slave). N is the operand and
// HI/LO width.
interface muldiv_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] Qa;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         div_by_zero;

    modport master (
        output start, op, Qa, B,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, Qa, B,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide into HI/LO.
// One multiplier/quotient bit per cycle, fixed N+1 cycle latency.
// op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
// Optional divider datapath: define MULDIV_DIVIDE_EN to include it. Without
// it, divide ops are accepted and complete in one cycle leaving HI/LO alone.
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
        return ~v + {{(N-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v);
        return ~v + {{(2*N-1){1'b0}}, 1'b1};
    endfunction

    state_t         state_r;
    logic           is_div_r;
    logic           sign_a_r;
    logic           sign_b_r;
    logic [N-1:0]   opnd_r;      // multiplicand (mul) or divisor (div)
    logic [2*N-1:0] acc_r;       // {upper, lower}: product or {remainder, quotient}
    logic [CW-1:0]  count_r;
    logic           busy_r;
    logic           done_r;
    logic [N-1:0]   hi_r;
    logic [N-1:0]   lo_r;
    logic           dbz_r;

    logic           a_neg_s;
    logic           b_neg_s;
    logic [N-1:0]   a_mag_s;
    logic [N-1:0]   b_mag_s;
    logic [N:0]     mul_sum_s;
    logic [2*N-1:0] mul_next_s;
    logic [2*N-1:0] prod_s;
    logic [2*N-1:0] iter_next_s;

`ifdef MULDIV_DIVIDE_EN
    logic           b_zero_r;
    logic [N:0]     trial_s;
    logic [2*N-1:0] div_next_s;
    logic [N-1:0]   quo_s;
    logic [N-1:0]   rem_s;
`endif

    // Operand magnitudes and signs at capture time (signed only for op[0]=1).
    always_comb begin
        a_neg_s = bus.op[0] & bus.Qa[N-1];
        b_neg_s = bus.op[0] & bus.B[N-1];
        a_mag_s = a_neg_s ? neg_n(bus.Qa) : bus.Qa;
        b_mag_s = b_neg_s ? neg_n(bus.B) : bus.B;
    end

    // Shift-add step: conditionally add multiplicand to upper half, shift right.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*N-1:N]} + (acc_r[0] ? {1'b0, opnd_r} : {(N+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_r[N-1:1]};
        prod_s     = (sign_a_r ^ sign_b_r) ? neg_2n(acc_r) : acc_r;
    end

`ifdef MULDIV_DIVIDE_EN
    // Restoring-division step and final sign correction of quotient/remainder.
    always_comb begin
        trial_s    = acc_r[2*N-1:N-1] - {1'b0, opnd_r};
        div_next_s = trial_s[N] ? {acc_r[2*N-2:0], 1'b0}
                                : {trial_s[N-1:0], acc_r[N-2:0], 1'b1};
        quo_s      = b_zero_r ? {N{1'b1}}
                   : ((sign_a_r ^ sign_b_r) ? neg_n(acc_r[N-1:0]) : acc_r[N-1:0]);
        // With B==0 the remainder is |Qa|, so restoring the sign yields Qa.
        rem_s      = sign_a_r ? neg_n(acc_r[2*N-1:N]) : acc_r[2*N-1:N];
        iter_next_s = is_div_r ? div_next_s : mul_next_s;
    end
`else
    // Only the multiplier datapath iterates in this build.
    always_comb begin
        iter_next_s = mul_next_s;
    end
`endif

    // Control FSM with iteration datapath and registered HI/LO/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            is_div_r <= 1'b0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            opnd_r   <= {N{1'b0}};
            acc_r    <= {(2*N){1'b0}};
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= {N{1'b0}};
            lo_r     <= {N{1'b0}};
            dbz_r    <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            b_zero_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        is_div_r <= bus.op[1];
                        sign_a_r <= a_neg_s;
                        sign_b_r <= b_neg_s;
                        dbz_r    <= 1'b0;
                        count_r  <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        if (bus.op[1]) begin
                            opnd_r <= b_mag_s;
                            acc_r  <= {{N{1'b0}}, a_mag_s};
                        end else begin
                            opnd_r <= a_mag_s;
                            acc_r  <= {{N{1'b0}}, b_mag_s};
                        end
`ifdef MULDIV_DIVIDE_EN
                        b_zero_r <= (bus.B == {N{1'b0}});
                        state_r  <= S_RUN;
`else
                        state_r  <= bus.op[1] ? S_FIX : S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    acc_r   <= iter_next_s;
                    count_r <= count_r + CW'(1);
                    if (count_r == CW'(N-1)) begin
                        state_r <= S_FIX;
                    end
                end
                S_FIX: begin
`ifdef MULDIV_DIVIDE_EN
                    if (is_div_r) begin
                        hi_r  <= rem_s;
                        lo_r  <= quo_s;
                        dbz_r <= b_zero_r;
                    end else begin
                        hi_r <= prod_s[2*N-1:N];
                        lo_r <= prod_s[N-1:0];
                    end
`else
                    if (!is_div_r) begin
                        hi_r <= prod_s[2*N-1:N];
                        lo_r <= prod_s[N-1:0];
                    end
`endif
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors plus hand sequences for muldiv_unit,
// checked through a scoreboard popped on every done pulse.
module tb_muldiv_unit;
    localparam int N   = 32;
    localparam int LAT = N + 1;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          start_cyc;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];
    vec_t vecs[12];

    // values HI/LO/div_by_zero must currently hold
    logic [31:0] mh;
    logic [31:0] ml;
    logic        mdbz;

    muldiv_unit_if #(.N(N)) bus ();

    muldiv_unit #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Result monitor: pops the scoreboard whenever done is seen.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"},   {32'd0, bus.hi}, {32'd0, e.hi});
                chk({e.name, "_lo"},   {32'd0, bus.lo}, {32'd0, e.lo});
                chk({e.name, "_dbz"},  {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
                chk({e.name, "_lat"},  64'(cyc - e.start_cyc), 64'(e.lat));
                chk({e.name, "_busy"}, {63'd0, bus.busy}, 64'd0);
                mh   = e.hi;
                ml   = e.lo;
                mdbz = e.dbz;
            end
        end
    end

    // Drive one request starting from a negedge; returns at the next negedge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed,
                         input string name);
        exp_t e;
        e.hi = eh; e.lo = el; e.dbz = ed; e.lat = LAT; e.name = name;
`ifndef MULDIV_DIVIDE_EN
        if (op[1]) begin
            e.hi = mh; e.lo = ml; e.dbz = 1'b0; e.lat = 1;
        end
`endif
        bus.op = op; bus.Qa = a; bus.B = b; bus.start = 1'b1;
        @(posedge clk);
        #1;
        e.start_cyc = cyc;
        sb.push_back(e);
        chk({name, "_busy_acc"}, {63'd0, bus.busy}, 64'd1);
        chk({name, "_dbz_clr"}, {63'd0, bus.div_by_zero}, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 2'($urandom); bus.Qa = $urandom; bus.B = $urandom;
    endtask

    // Wait (bounded) until every expected result has been seen.
    task automatic drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk({name, "_drain"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p;
        logic        got;
        n_cmp = 0; n_fail = 0; cyc = 0;
        mh = 32'd0; ml = 32'd0; mdbz = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.Qa = 32'd0; bus.B = 32'd0;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg3x7"};
        vecs[2]  = '{2'b00, 32'h00010000, 32'h0000FFFF, 32'h00000000, 32'hFFFF0000, 1'b0, "multu_imm"};
        vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg7by2"};
        vecs[4]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "divu_100by7"};
        vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_ovf"};
        vecs[6]  = '{2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, "divu_by0"};
        vecs[7]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_minsq"};
        vecs[8]  = '{2'b01, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, "mult_7xneg1"};
        vecs[9]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_7byneg2"};
        vecs[10] = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, "div_neg_by0"};
        vecs[11] = '{2'b01, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, "mult_zero"};

        // reset state
        #1;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_hi",   {32'd0, bus.hi}, 64'd0);
        chk("rst_lo",   {32'd0, bus.lo}, 64'd0);
        chk("rst_dbz",  {63'd0, bus.div_by_zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // table-driven vectors
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                  vecs[i].exp_dbz, vecs[i].name);
            drain(vecs[i].name);
            repeat (2) @(negedge clk);
            chk({vecs[i].name, "_hold_hi"},  {32'd0, bus.hi}, {32'd0, mh});
            chk({vecs[i].name, "_hold_lo"},  {32'd0, bus.lo}, {32'd0, ml});
            chk({vecs[i].name, "_hold_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, mdbz});
        end

        // start pulses while busy are ignored; HI/LO hold during RUN
        p = {32'd0, 32'h0000ABCD} * {32'd0, 32'h00001234};
        issue(2'b00, 32'h0000ABCD, 32'h00001234, p[63:32], p[31:0], 1'b0, "busy_ign");
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.Qa = 32'd9; bus.B = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        chk("run_hold_hi", {32'd0, bus.hi}, {32'd0, mh});
        chk("run_hold_lo", {32'd0, bus.lo}, {32'd0, ml});
        bus.start = 1'b1; bus.op = 2'b01; bus.Qa = 32'hFFFFFFFF; bus.B = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        drain("busy_ign");
        repeat (6) @(negedge clk);

        // back-to-back: start during the done cycle
        p = {32'd0, 32'h00C0FFEE} * {32'd0, 32'h00000321};
        issue(2'b00, 32'h00C0FFEE, 32'h00000321, p[63:32], p[31:0], 1'b0, "b2b_first");
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("b2b_done_seen", {63'd0, got}, 64'd1);
        issue(2'b01, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd0, 32'd15, 1'b0, "b2b_second");
        drain("b2b");

        // asynchronous reset in the middle of RUN
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "aborted");
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, bus.busy}, 64'd0);
        chk("arst_done", {63'd0, bus.done}, 64'd0);
        chk("arst_hi",   {32'd0, bus.hi}, 64'd0);
        chk("arst_lo",   {32'd0, bus.lo}, 64'd0);
        chk("arst_dbz",  {63'd0, bus.div_by_zero}, 64'd0);
        sb.delete();
        mh = 32'd0; ml = 32'd0; mdbz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "post_rst");
        drain("post_rst");
        repeat (40) @(negedge clk);
        chk("post_rst_idle", 64'(sb.size()) + {63'd0, bus.busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS execute stage. It sits directly downstream of the immediate-or-register operand mux: operand B is that mux's N-bit output (zero-extended immediate or register Qs), and operand A is the register-file Qa. It computes 2N-bit products and quotient/remainder pairs over multiple cycles into HI/LO registers, using a start/busy/done handshake toward the control unit.

## Interface
- N, default 32 (from the_pkg): operand and HI/LO width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- Qa  in  N  operand A (rs / dividend / multiplicand).
- B  in  N  operand B from the ImmorReg mux (rt or zero-extended imm; divisor / multiplier).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO are updated.
- hi  out  N  HI register (product upper half / remainder).
- lo  out  N  LO register (product lower half / quotient).
- div_by_zero  out  1  set with done when a divide had B==0; held until the next accepted start.

## Operation
- Reset values: state IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0.
- FSM: IDLE -> RUN -> FIX -> IDLE.
- IDLE: on start=1, capture op, |Qa|, |B| (magnitudes for signed ops, raw values for unsigned), result signs, B==0 flag; clear div_by_zero; count=0; go to RUN.
- RUN: one iteration per cycle, count 0..N-1; leave for FIX after the iteration with count=N-1.
  - Multiply: shift-add on a 2N-bit accumulator, 1 multiplier bit per cycle.
  - Divide: restoring division, 1 quotient bit per cycle, N+1-bit trial subtract.
- FIX: apply signs, write hi/lo, pulse done, return to IDLE.
  - MULT: negate 2N-bit product when sign(A) xor sign(B).
  - DIV: quotient negated when signs differ; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
  - Divide with B==0: hi=Qa unmodified, lo=all ones, div_by_zero=1. Latency is unchanged.
- hi/lo change only in FIX. They hold their previous values throughout RUN.
- start while busy is ignored; Qa, B, and op are don't-care after capture.

## Timing
- Start sampled at edge k. busy=1 after edge k. FIX executes at edge k+N+1. done=1 and busy=0 for the cycle after edge k+N+1.
- Fixed latency of N+1 cycles (33 for N=32) for every op.
- start during the done cycle: the FSM is already in IDLE, so the new request is accepted back-to-back.
- rst_n low at any time, including mid-RUN: all outputs and state return to reset values immediately (asynchronously). The aborted operation leaves no trace.

## Configuration
- MULDIV_DIVIDE_EN defined: full behaviour above.
- Not defined: divider datapath omitted.
  - ops 10 and 11 are accepted, then go IDLE -> FIX directly. done pulses after edge k+1.
  - hi/lo are unchanged and div_by_zero stays 0.
  - Multiply ops are unaffected.

## Test plan
- MULTU Qa=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done exactly 33 cycles after start; busy high for cycles 1-32.
- MULT Qa=0xFFFFFFFD (-3), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULTU Qa=0x00010000, B=0x0000FFFF (zero-extended imm) -> hi=0, lo=0xFFFF0000.
- DIV Qa=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU Qa=100, B=7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU Qa=5, B=0 -> done at cycle 33, div_by_zero=1, hi=5, lo=0xFFFFFFFF. The next accepted start clears div_by_zero the following cycle.
- start pulsed at cycles 5 and 20 of an operation -> ignored and the result is unaffected. start during the done cycle -> the second op completes 33 cycles later.
- rst_n low at RUN iteration 10 -> busy, done, hi, lo all 0 before the next edge. After release, MULTU 3*4 -> lo=12, hi=0.
- Without MULDIV_DIVIDE_EN: DIVU 100/7 -> done after 1 cycle, hi/lo unchanged, div_by_zero=0.
